// File: rtl/ff_share_arbiter.sv
// Round-robin arbiter granting NREQ requesters write access to one shared WIDTH-bit register.
// Define FFARB_LOCK_EN to add the lock input that lets the current owner commit back-to-back.
module ff_share_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                    Clock,
  input  logic                    Resetn,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   wdata,
  input  logic                    Clear,
`ifdef FFARB_LOCK_EN
  input  logic                    lock,
`endif
  output logic [NREQ-1:0]         gnt,
  output logic                    ack,
  output logic [WIDTH-1:0]        Q,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    busy
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, GRANT, COMMIT} state_t;

  state_t        state, state_next;
  logic [IW-1:0] ptr, gidx, pick_idx;
  logic          pick_found, held, lock_hold;

  assign held = req[gidx];

`ifdef FFARB_LOCK_EN
  assign lock_hold = lock & held;
`else
  assign lock_hold = 1'b0;
`endif

  // Search from ptr upward; walking offsets downward lets the nearest hit win.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      if (req[(int'(ptr) + off) % NREQ]) begin
        pick_found = 1'b1;
        pick_idx   = IW'((int'(ptr) + off) % NREQ);
      end
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!Clear && pick_found) state_next = GRANT;
      GRANT:   state_next = held ? COMMIT : IDLE;
      COMMIT:  state_next = lock_hold ? GRANT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ack  = (state == COMMIT);
    busy = (state != IDLE);
  end

  // Clear only acts in IDLE; the commit edge is the GRANT->COMMIT transition.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      gnt   <= '0;
      gidx  <= '0;
      ptr   <= '0;
      Q     <= '0;
      owner <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Clear) begin
            Q <= '0;
          end else if (pick_found) begin
            gnt  <= NREQ'(1) << pick_idx;
            gidx <= pick_idx;
          end
        end
        GRANT: begin
          gnt <= '0;
          if (held) begin
            Q     <= wdata[int'(gidx)*WIDTH +: WIDTH];
            owner <= gidx;
          end
        end
        COMMIT: begin
          if (lock_hold) gnt <= NREQ'(1) << gidx;
          else           ptr <= (int'(gidx) == NREQ - 1) ? '0 : gidx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ff_share_arbiter.sv
// Randomised self-checking bench for ff_share_arbiter against a transaction-level
// round-robin model (pointer, register value and last owner kept as plain integers).
module tb_ff_share_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic                  Clock = 1'b0;
  logic                  Resetn;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] wdata;
  logic                  Clear;
`ifdef FFARB_LOCK_EN
  logic                  lock;
`endif
  logic [NREQ-1:0]       gnt;
  logic                  ack;
  logic [WIDTH-1:0]      Q;
  logic [1:0]            owner;
  logic                  busy;

  int checks = 0;
  int errors = 0;
  int m_ptr;
  int m_owner;
  logic [WIDTH-1:0] m_q;

  ff_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .Clock(Clock), .Resetn(Resetn), .req(req), .wdata(wdata), .Clear(Clear),
`ifdef FFARB_LOCK_EN
    .lock(lock),
`endif
    .gnt(gnt), .ack(ack), .Q(Q), .owner(owner), .busy(busy)
  );

  always #5 Clock = ~Clock;

  // Reference: first requesting index at or after p, wrapping around.
  function automatic int rr_pick(input int p, input logic [NREQ-1:0] r);
    for (int k = 0; k < NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [WIDTH-1:0] data_of(input int i);
    return wdata[i*WIDTH +: WIDTH];
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int i);
    logic [NREQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic model_reset;
    m_ptr = 0; m_owner = 0; m_q = '0;
  endtask

  task automatic model_commit(input int i);
    m_q = data_of(i); m_owner = i; m_ptr = (i + 1) % NREQ;
  endtask

  task automatic test_reset;
    Resetn = 1'b0; req = '0; wdata = '0; Clear = 1'b0;
`ifdef FFARB_LOCK_EN
    lock = 1'b0;
`endif
    model_reset();
    repeat (2) @(posedge Clock);
    #1;
    checks++;
    if ({gnt, ack, Q, owner, busy} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_state got gnt=%b ack=%b Q=%h owner=%0d busy=%b exp all 0", gnt, ack, Q, owner, busy);
    end
    #2 Resetn = 1'b1;
  endtask

  task automatic test_single;
    wdata[7:0] = 8'hA5; req = 4'b0001;
    tick();
    checks++;
    if (gnt !== 4'b0001 || busy !== 1'b1) begin
      errors++; $display("[TB] FAIL single_gnt got gnt=%b busy=%b exp 0001 1", gnt, busy);
    end
    tick();
    checks++;
    if (Q !== 8'hA5 || ack !== 1'b1 || gnt !== 4'b0000) begin
      errors++; $display("[TB] FAIL single_commit got Q=%h ack=%b gnt=%b exp a5 1 0000", Q, ack, gnt);
    end
    model_commit(0);
    req = '0;
    tick();
    checks++;
    if (busy !== 1'b0 || ack !== 1'b0 || owner !== 2'd0) begin
      errors++; $display("[TB] FAIL single_idle got busy=%b ack=%b owner=%0d exp 0 0 0", busy, ack, owner);
    end
  endtask

  task automatic test_rotation;
    int exp;
    wdata = {8'h13, 8'h12, 8'h11, 8'h10};
    req = 4'b1111;
    for (int n = 0; n < 8; n++) begin
      exp = rr_pick(m_ptr, req);
      tick();
      checks++;
      if (gnt !== onehot(exp) || ack !== 1'b0) begin
        errors++; $display("[TB] FAIL rot_gnt[%0d] got gnt=%b ack=%b exp %b 0", n, gnt, ack, onehot(exp));
      end
      tick();
      model_commit(exp);
      checks++;
      if (ack !== 1'b1 || Q !== m_q) begin
        errors++; $display("[TB] FAIL rot_commit[%0d] got ack=%b Q=%h exp 1 %h", n, ack, Q, m_q);
      end
      tick();
      checks++;
      if (ack !== 1'b0 || busy !== 1'b0 || owner !== 2'(m_owner)) begin
        errors++; $display("[TB] FAIL rot_idle[%0d] got ack=%b busy=%b owner=%0d exp 0 0 %0d", n, ack, busy, owner, m_owner);
      end
    end
    req = '0;
  endtask

  task automatic test_wrap;
    int exp;
    logic [NREQ-1:0] seq [3];
    seq[0] = 4'b0100; seq[1] = 4'b0101; seq[2] = 4'b0100;
    wdata = {8'h33, 8'h22, 8'h11, 8'h00};
    for (int n = 0; n < 3; n++) begin
      req = seq[n];
      exp = rr_pick(m_ptr, req);
      tick();
      checks++;
      if (gnt !== onehot(exp)) begin
        errors++; $display("[TB] FAIL wrap_gnt[%0d] got %b exp %b", n, gnt, onehot(exp));
      end
      tick();
      model_commit(exp);
      checks++;
      if (ack !== 1'b1 || Q !== m_q) begin
        errors++; $display("[TB] FAIL wrap_commit[%0d] got ack=%b Q=%h exp 1 %h", n, ack, Q, m_q);
      end
      req = '0;
      tick();
    end
  endtask

  task automatic test_abort;
    int exp;
    wdata = {8'h44, 8'h33, 8'h77, 8'h66};
    req = 4'b0001;
    tick(); tick();
    model_commit(0);
    req = '0;
    tick();
    req = 4'b0010;
    tick();
    checks++;
    if (gnt !== 4'b0010) begin
      errors++; $display("[TB] FAIL abort_gnt got %b exp 0010", gnt);
    end
    req = '0;
    tick();
    checks++;
    if (gnt !== '0 || ack !== 1'b0 || busy !== 1'b0 || Q !== m_q) begin
      errors++; $display("[TB] FAIL abort_drop got gnt=%b ack=%b busy=%b Q=%h exp 0 0 0 %h", gnt, ack, busy, Q, m_q);
    end
    tick();
    checks++;
    if (ack !== 1'b0 || Q !== m_q) begin
      errors++; $display("[TB] FAIL abort_noack got ack=%b Q=%h exp 0 %h", ack, Q, m_q);
    end
    req = 4'b1111;
    exp = rr_pick(m_ptr, req);
    tick();
    checks++;
    if (gnt !== onehot(exp)) begin
      errors++; $display("[TB] FAIL abort_regrant got %b exp %b", gnt, onehot(exp));
    end
    tick();
    model_commit(exp);
    req = '0;
    tick();
  endtask

  task automatic test_clear;
    wdata = {8'h00, 8'h00, 8'h5A, 8'h00};
    req = 4'b0010;
    tick(); tick();
    model_commit(1);
    req = '0;
    tick();
    Clear = 1'b1; req = 4'b0010; wdata[15:8] = 8'hC3;
    tick();
    m_q = '0;
    checks++;
    if (Q !== m_q || gnt !== '0 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL clear_idle got Q=%h gnt=%b busy=%b exp 00 0000 0", Q, gnt, busy);
    end
    Clear = 1'b0;
    tick();
    checks++;
    if (gnt !== 4'b0010) begin
      errors++; $display("[TB] FAIL clear_then_gnt got %b exp 0010", gnt);
    end
    Clear = 1'b1;
    tick();
    model_commit(1);
    checks++;
    if (Q !== m_q || ack !== 1'b1) begin
      errors++; $display("[TB] FAIL clear_ignored_grant got Q=%h ack=%b exp %h 1", Q, ack, m_q);
    end
    req = '0;
    tick();
    checks++;
    if (Q !== m_q) begin
      errors++; $display("[TB] FAIL clear_ignored_commit got Q=%h exp %h", Q, m_q);
    end
    Clear = 1'b0;
  endtask

  task automatic test_reset_commit;
    wdata[7:0] = 8'h9C; req = 4'b0001;
    tick(); tick();
    checks++;
    if (ack !== 1'b1) begin
      errors++; $display("[TB] FAIL rst_pre_ack got %b exp 1", ack);
    end
    #2 Resetn = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({gnt, ack, Q, owner, busy} !== '0) begin
      errors++; $display("[TB] FAIL rst_async got gnt=%b ack=%b Q=%h owner=%0d busy=%b exp all 0", gnt, ack, Q, owner, busy);
    end
    #2 Resetn = 1'b1;
    tick();
    checks++;
    if (gnt !== 4'b0001) begin
      errors++; $display("[TB] FAIL rst_first_gnt got %b exp 0001", gnt);
    end
    tick();
    model_commit(0);
    req = '0;
    tick();
  endtask

  task automatic test_random;
    int exp;
    for (int n = 0; n < 40; n++) begin
      wdata = {$urandom, $urandom} & {(NREQ*WIDTH){1'b1}};
      req = NREQ'($urandom_range(1, 15));
      exp = rr_pick(m_ptr, req);
      tick();
      checks++;
      if (gnt !== onehot(exp)) begin
        errors++; $display("[TB] FAIL rand_gnt[%0d] got %b exp %b", n, gnt, onehot(exp));
      end
      req = NREQ'($urandom) | onehot(exp);
      Clear = 1'($urandom);
      tick();
      model_commit(exp);
      checks++;
      if (ack !== 1'b1 || Q !== m_q || gnt !== '0) begin
        errors++; $display("[TB] FAIL rand_commit[%0d] got ack=%b Q=%h gnt=%b exp 1 %h 0000", n, ack, Q, gnt, m_q);
      end
      req = NREQ'($urandom);
      tick();
      Clear = 1'b0;
      checks++;
      if (busy !== 1'b0 || owner !== 2'(m_owner) || Q !== m_q) begin
        errors++; $display("[TB] FAIL rand_idle[%0d] got busy=%b owner=%0d Q=%h exp 0 %0d %h", n, busy, owner, Q, m_owner, m_q);
      end
    end
    req = '0;
    tick();
  endtask

`ifdef FFARB_LOCK_EN
  task automatic test_lock;
    lock = 1'b1;
    wdata = {8'h01, 8'h00, 8'h00, 8'h00};
    req = 4'b1000;
    tick();
    checks++;
    if (gnt !== 4'b1000) begin
      errors++; $display("[TB] FAIL lock_gnt got %b exp 1000", gnt);
    end
    tick();
    checks++;
    if (Q !== 8'h01 || ack !== 1'b1) begin
      errors++; $display("[TB] FAIL lock_commit1 got Q=%h ack=%b exp 01 1", Q, ack);
    end
    wdata[31:24] = 8'h02; req = 4'b1111;
    tick();
    checks++;
    if (gnt !== 4'b1000) begin
      errors++; $display("[TB] FAIL lock_regrant got %b exp 1000", gnt);
    end
    tick();
    checks++;
    if (Q !== 8'h02 || ack !== 1'b1) begin
      errors++; $display("[TB] FAIL lock_commit2 got Q=%h ack=%b exp 02 1", Q, ack);
    end
    lock = 1'b0; req = '0;
    m_q = 8'h02; m_owner = 3; m_ptr = 0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_wrap();
    test_abort();
    test_clear();
    test_reset_commit();
    test_random();
`ifdef FFARB_LOCK_EN
    test_lock();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ff_share_arbiter.md
# ff_share_arbiter

Round-robin arbiter that shares one WIDTH-bit storage register (an lpm_ff-style register with a clock and asynchronous clear) between NREQ requesters. It accepts write requests, grants one requester at a time through a req/gnt/ack handshake, and commits the granted requester's data into the register. It sits between the requesting datapath blocks and the shared register, and is the only writer of that register.

## Interface
- NREQ, 4: number of requesters, 2..8.
- WIDTH, 8: width of the shared register.
- Clock  in  1  single clock; all state changes on the rising edge.
- Resetn  in  1  asynchronous, active-low reset; clears all state and the register.
- req  in  NREQ  per-requester write request, level-sensitive.
- wdata  in  NREQ*WIDTH  per-requester write data; requester i occupies bits [i*WIDTH +: WIDTH].
- Clear  in  1  synchronous clear request for the shared register.
- gnt  out  NREQ  one-hot grant, registered.
- ack  out  1  one-cycle pulse marking the commit edge.
- Q  out  WIDTH  shared register contents.
- owner  out  clog2(NREQ)  index of the last requester that committed.
- busy  out  1  high in any state other than IDLE.

## Operation
- The FSM has three states: IDLE, GRANT and COMMIT. Reset enters IDLE with a round-robin pointer ptr = 0.
- In IDLE with Clear = 1:
  - Q is set to 0 on the next edge.
  - No grant is issued.
  - Clear takes priority over every request.
- In IDLE with any req bit set and Clear = 0:
  - Select the first set req bit searching ptr, ptr+1, ... modulo NREQ.
  - Register gnt for that bit and go to GRANT.
- In GRANT:
  - If the granted req is still 1, go to COMMIT. Q loads that requester's wdata on the same edge.
  - If the granted req has dropped, abort: clear gnt, return to IDLE, leave Q and ptr unchanged.
- In COMMIT:
  - ack = 1 and gnt is cleared.
  - owner = granted index.
  - ptr = (granted index + 1) mod NREQ.
  - Next state is IDLE.
- Requesters hold req and wdata stable from request until they see ack. They drop req in the ack cycle or re-request for another write.
- req changes on non-granted lines never disturb an active transaction.
- Clear asserted outside IDLE is ignored. It is not queued.
- Q changes only on a commit edge, on a Clear in IDLE, or on reset.

## Timing
- Reset values: gnt = 0, ack = 0, Q = 0, owner = 0, busy = 0, ptr = 0, state = IDLE.
- With req sampled at edge N in IDLE:
  - gnt is high after edge N.
  - Q is updated after edge N+1.
  - ack is high for the cycle after edge N+1.
  - The state is back in IDLE after edge N+2.
- Minimum spacing between commits is 3 cycles. Back-to-back requesters see gnt 3 cycles apart.
- Resetn low at any point clears all state immediately, without waiting for Clock. A grant in flight is lost and no ack is issued.
- Deassertion of Resetn is synchronised externally. The first grant can occur on the first edge after release.
- Fairness: with all req held high, grants rotate 0,1,2,3,0,... No requester waits more than NREQ commits.

## Configuration
- FFARB_LOCK_EN, when defined, adds an input port lock (1 bit). In COMMIT, if lock = 1 and the granted req is still 1:
  - Go directly to GRANT with the same gnt.
  - ptr is not advanced.
  - This gives a back-to-back commit every 2 cycles for the locked owner.
- Clear is still ignored while the lock is held.
- With FFARB_LOCK_EN undefined, the lock port is absent and behaviour is exactly as in Operation.

## Test plan
- Reset, then req = 0001 with wdata[7:0] = 0xA5 -> gnt = 0001 one cycle later, Q = 0xA5 and ack = 1 at cycle 2, owner = 0, busy low at cycle 3.
- req = 1111 held for 8 commits with wdata = 0x10, 0x11, 0x12, 0x13 -> grant order 0,1,2,3,0,1,2,3, Q follows the granted data, ack every 3 cycles.
- After a commit by requester 2, raise req = 0101 -> the next grant goes to 0 (ptr = 3 wraps to 0), then to 2.
- Requester 1 granted, then drops req during GRANT -> no ack, Q unchanged, ptr unchanged, and a re-request by 1 is granted next.
- Q = 0x5A, Clear and req = 0010 raised together in IDLE -> Q = 0 and no gnt that cycle; then requester 1 is granted.
- Resetn pulsed low during COMMIT -> gnt, ack, Q, owner and busy are all 0 immediately. With FFARB_LOCK_EN and lock = 1, requester 3 commits 0x01 and 0x02 two cycles apart, with no grant to the others in between.
